pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Decode plus pipelined control for the 5-stage core. Decodes opcode/funct in ID
//  and carries control through ID/EX, EX/MEM and MEM/WB registers. Adds per-funct ALU
//  select, destination resolution, load-use interlock, branch/jump flush and a stall counter.
// PARAMETERS
//  REG_AW         5   register address width
//  ALU_OP_W       3   ALU op width; encoding ADD=0 SUB=1 AND=2 OR=3 SLT=4
//  STALL_CNT_W    16  stall counter width (saturating)
//  LOAD_USE_STALL 1   1 = load-use interlock enabled; 0 = stall_o tied 0
// PORTS
//  clk            in   1            clock
//  reset          in   1            synchronous, active-high reset
//  id_valid       in   1            instruction in ID is valid
//  id_opcode      in   6            instr[31:26]
//  id_funct       in   6            instr[5:0]
//  id_rs/id_rt/id_rd in REG_AW      source and destination fields
//  ex_branch_taken in  1            EX comparator result for the branch in EX
//  stall_o        out  1            hold PC and IF/ID (comb)
//  flush_ifid_o   out  1            clear IF/ID on next edge (comb)
//  jump_o         out  1            J decoded in ID; PC takes jump target (comb)
//  illegal_o      out  1            valid undecodable instruction in ID (comb)
//  ex_valid, ex_alu_op[ALU_OP_W], ex_alu_src, ex_branch, ex_dst[REG_AW]   out  ID/EX regs
//  mem_read, mem_write, mem_dst[REG_AW], mem_reg_write                     out  EX/MEM regs
//  wb_reg_write, wb_mem_to_reg, wb_dst[REG_AW]                             out  MEM/WB regs
//  stall_count    out  STALL_CNT_W  count of stall cycles since reset
// BEHAVIOUR
//  Decode: R(000000) funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT;
//   ADDI 001000 ADD,src=imm; LW 100011 ADD,imm,read,m2r; SW 101011 ADD,imm,write;
//   BEQ 000100 SUB,branch; J 000010 jump only. Any other opcode/funct = illegal.
//  Dest: R -> rd; ADDI/LW -> rt; others none. reg_write forced 0 when dest == 0.
//  Sources used: rs for R/ADDI/LW/SW/BEQ; rt for R/SW/BEQ.
//  Bubble = all control 0, valid 0. Illegal, !id_valid, J and squashed slots enter ID/EX as bubbles.
//  Load-use: stall_o=1 when ex_valid & ID/EX is LW & ex_dst!=0 & ex_dst equals a used
//   source of the valid ID instruction. While stalled, ID/EX takes a bubble and
//   ID is re-presented by the outside. jump_o and illegal_o are masked while stalled.
//  Branch: ex_branch & ex_branch_taken -> flush_ifid_o=1. ID/EX takes a bubble;
//   stall_o forced 0 (flush beats stall). jump_o and illegal_o are masked.
//  Jump: J in ID, not stalled, not flushed -> jump_o=1 and flush_ifid_o=1 (one delay slot squashed).
//  EX/MEM and MEM/WB advance every cycle unconditionally; bubbles propagate as zeros.
//  Latency: ID decode to wb_* is exactly 3 clk edges when not stalled.
//  stall_count += 1 on each edge with stall_o=1; saturates at all-ones (no wrap).
//  Reset: every pipeline register, valid and stall_count = 0. stall_o, flush_ifid_o,
//   jump_o and illegal_o are 0 while reset is high.
//   Reset mid-stall or mid-flush drops all in-flight control on the same edge.
// TESTING
//  ADD r3,r1,r2 (funct 100000) -> 3 edges later wb_reg_write=1, wb_dst=3, mem_to_reg=0.
//  LW r5 then ADD r6,r5,r1 -> stall_o=1 for one cycle, one bubble in EX, stall_count=1.
//   Same sequence with LOAD_USE_STALL=0 -> no stall.
//  BEQ in EX with ex_branch_taken=1 while ID holds LW -> flush_ifid_o=1, ID/EX bubble,
//   no mem_read 2 cycles later.
//  J in ID -> jump_o=1 and flush_ifid_o=1 for one cycle; the J never asserts any ex_/mem_/wb_ signal.
//  ADDI r0 and opcode 111111 -> wb_reg_write stays 0; illegal_o=1 for the 111111 cycle.
//  Force 2^STALL_CNT_W+3 load-use stalls -> stall_count holds all-ones.
//   Reset high mid-stall -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - decode and pipelined control for the 5-stage core
//
// Decodes opcode/funct in ID and carries control through ID/EX, EX/MEM and
// MEM/WB. Adds per-funct ALU select, destination resolution, load-use
// interlock, branch/jump flush of IF/ID and a saturating stall counter.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_valid                   instruction in ID is valid
//   id_opcode, id_funct        instr[31:26], instr[5:0]
//   id_rs, id_rt, id_rd        register fields of the ID instruction
//   ex_branch_taken            comparator result for the branch sitting in EX
//   stall_o                    hold PC and IF/ID (combinational)
//   flush_ifid_o               clear IF/ID on the next edge (combinational)
//   jump_o                     J decoded in ID, PC takes jump target (combinational)
//   illegal_o                  valid undecodable instruction in ID (combinational)
//   ex_*                       ID/EX control registers
//   mem_*                      EX/MEM control registers
//   wb_*                       MEM/WB control registers
//   stall_count                saturating count of stall cycles since reset

module pipe_ctrl_unit #(
  parameter int REG_AW         = 5,
  parameter int ALU_OP_W       = 3,
  parameter int STALL_CNT_W    = 16,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [5:0]             id_opcode,
  input  logic [5:0]             id_funct,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   ex_branch_taken,
  output logic                   stall_o,
  output logic                   flush_ifid_o,
  output logic                   jump_o,
  output logic                   illegal_o,
  output logic                   ex_valid,
  output logic [ALU_OP_W-1:0]    ex_alu_op,
  output logic                   ex_alu_src,
  output logic                   ex_branch,
  output logic [REG_AW-1:0]      ex_dst,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [REG_AW-1:0]      mem_dst,
  output logic                   mem_reg_write,
  output logic                   wb_reg_write,
  output logic                   wb_mem_to_reg,
  output logic [REG_AW-1:0]      wb_dst,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);

  // Decode results for the instruction currently in ID
  logic                d_legal;
  logic                d_jump;
  logic [ALU_OP_W-1:0] d_alu_op;
  logic                d_alu_src;
  logic                d_branch;
  logic                d_mem_read;
  logic                d_mem_write;
  logic                d_mem_to_reg;
  logic                d_writes;
  logic [REG_AW-1:0]   d_dst;
  logic                d_use_rs;
  logic                d_use_rt;

  // ID/EX fields that are not visible as ports but travel down the pipe
  logic ex_mem_read_q;
  logic ex_mem_write_q;
  logic ex_mem_to_reg_q;
  logic ex_reg_write_q;
  logic mem_mem_to_reg_q;

  logic branch_flush;
  logic load_use_hit;
  logic id_bubble;

  always_comb begin
    d_legal      = 1'b0;
    d_jump       = 1'b0;
    d_alu_op     = ALU_ADD;
    d_alu_src    = 1'b0;
    d_branch     = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_writes     = 1'b0;
    d_dst        = '0;
    d_use_rs     = 1'b0;
    d_use_rt     = 1'b0;
    case (id_opcode)
      OP_R: begin
        d_writes = 1'b1;
        d_dst    = id_rd;
        d_use_rs = 1'b1;
        d_use_rt = 1'b1;
        d_legal  = 1'b1;
        case (id_funct)
          FN_ADD:  d_alu_op = ALU_ADD;
          FN_SUB:  d_alu_op = ALU_SUB;
          FN_AND:  d_alu_op = ALU_AND;
          FN_OR:   d_alu_op = ALU_OR;
          FN_SLT:  d_alu_op = ALU_SLT;
          default: begin
            // Unknown funct: illegal, and it must not claim any sources
            d_legal  = 1'b0;
            d_writes = 1'b0;
            d_dst    = '0;
            d_use_rs = 1'b0;
            d_use_rt = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        d_legal   = 1'b1;
        d_alu_src = 1'b1;
        d_writes  = 1'b1;
        d_dst     = id_rt;
        d_use_rs  = 1'b1;
      end
      OP_LW: begin
        d_legal      = 1'b1;
        d_alu_src    = 1'b1;
        d_mem_read   = 1'b1;
        d_mem_to_reg = 1'b1;
        d_writes     = 1'b1;
        d_dst        = id_rt;
        d_use_rs     = 1'b1;
      end
      OP_SW: begin
        d_legal     = 1'b1;
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
        d_use_rs    = 1'b1;
        d_use_rt    = 1'b1;
      end
      OP_BEQ: begin
        d_legal  = 1'b1;
        d_alu_op = ALU_SUB;
        d_branch = 1'b1;
        d_use_rs = 1'b1;
        d_use_rt = 1'b1;
      end
      OP_J: begin
        d_legal = 1'b1;
        d_jump  = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
  end

  assign branch_flush = !reset && ex_branch && ex_branch_taken;

  assign load_use_hit = ex_valid && ex_mem_read_q && (ex_dst != '0) && id_valid &&
                        ((d_use_rs && (id_rs == ex_dst)) || (d_use_rt && (id_rt == ex_dst)));

  // A taken branch squashes the ID instruction anyway, so it wins over a stall
  assign stall_o      = (LOAD_USE_STALL != 0) && !reset && !branch_flush && load_use_hit;
  assign jump_o       = !reset && id_valid && d_jump && !stall_o && !branch_flush;
  assign illegal_o    = !reset && id_valid && !d_legal && !stall_o && !branch_flush;
  assign flush_ifid_o = branch_flush || jump_o;

  assign id_bubble = stall_o || branch_flush || !id_valid || !d_legal || d_jump;

  // ID/EX
  always_ff @(posedge clk) begin
    if (reset || id_bubble) begin
      ex_valid        <= 1'b0;
      ex_alu_op       <= '0;
      ex_alu_src      <= 1'b0;
      ex_branch       <= 1'b0;
      ex_dst          <= '0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_reg_write_q  <= 1'b0;
    end else begin
      ex_valid        <= 1'b1;
      ex_alu_op       <= d_alu_op;
      ex_alu_src      <= d_alu_src;
      ex_branch       <= d_branch;
      ex_dst          <= d_dst;
      ex_mem_read_q   <= d_mem_read;
      ex_mem_write_q  <= d_mem_write;
      ex_mem_to_reg_q <= d_mem_to_reg;
      // Writes to r0 are discarded at decode so nothing downstream sees them
      ex_reg_write_q  <= d_writes && (d_dst != '0);
    end
  end

  // EX/MEM and MEM/WB advance every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      mem_reg_write    <= 1'b0;
      mem_dst          <= '0;
      mem_mem_to_reg_q <= 1'b0;
      wb_reg_write     <= 1'b0;
      wb_mem_to_reg    <= 1'b0;
      wb_dst           <= '0;
    end else begin
      mem_read         <= ex_mem_read_q;
      mem_write        <= ex_mem_write_q;
      mem_reg_write    <= ex_reg_write_q;
      mem_dst          <= ex_dst;
      mem_mem_to_reg_q <= ex_mem_to_reg_q;
      wb_reg_write     <= mem_reg_write;
      wb_mem_to_reg    <= mem_mem_to_reg_q;
      wb_dst           <= mem_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_o && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed vector bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_branch_taken;

  logic       stall_o, flush_ifid_o, jump_o, illegal_o;
  logic       ex_valid, ex_alu_src, ex_branch;
  logic [2:0] ex_alu_op;
  logic [4:0] ex_dst, mem_dst, wb_dst;
  logic       mem_read, mem_write, mem_reg_write, wb_reg_write, wb_mem_to_reg;
  logic [2:0] stall_count;

  logic       n_stall, n_flush, n_jump, n_illegal;
  logic       n_ex_valid, n_ex_alu_src, n_ex_branch;
  logic [2:0] n_ex_alu_op;
  logic [4:0] n_ex_dst, n_mem_dst, n_wb_dst;
  logic       n_mem_read, n_mem_write, n_mem_reg_write, n_wb_reg_write, n_wb_mem_to_reg;
  logic [15:0] n_stall_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.STALL_CNT_W(3)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .stall_o(stall_o), .flush_ifid_o(flush_ifid_o),
    .jump_o(jump_o), .illegal_o(illegal_o), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_dst(ex_dst), .mem_read(mem_read),
    .mem_write(mem_write), .mem_dst(mem_dst), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
    .stall_count(stall_count)
  );

  pipe_ctrl_unit #(.LOAD_USE_STALL(0)) dut_ns (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .stall_o(n_stall), .flush_ifid_o(n_flush),
    .jump_o(n_jump), .illegal_o(n_illegal), .ex_valid(n_ex_valid), .ex_alu_op(n_ex_alu_op),
    .ex_alu_src(n_ex_alu_src), .ex_branch(n_ex_branch), .ex_dst(n_ex_dst),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .mem_dst(n_mem_dst),
    .mem_reg_write(n_mem_reg_write), .wb_reg_write(n_wb_reg_write),
    .wb_mem_to_reg(n_wb_mem_to_reg), .wb_dst(n_wb_dst), .stall_count(n_stall_count)
  );

  typedef struct {
    logic       v;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic       bt;
    logic [3:0] comb;   // {stall, flush, jump, illegal} before the edge
    logic       exv;
    logic [2:0] aop;
    logic       src, br;
    logic [4:0] exd;
    logic       mr, mw, mrw;
    logic [4:0] md;
    logic       wrw, wm2r;
    logic [4:0] wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [5:0] op, logic [5:0] fn, logic [4:0] rs,
                              logic [4:0] rt, logic [4:0] rd, logic bt, logic [3:0] comb,
                              logic exv, logic [2:0] aop, logic src, logic br, logic [4:0] exd,
                              logic mr, logic mw, logic mrw, logic [4:0] md,
                              logic wrw, logic wm2r, logic [4:0] wd);
    vec_t r;
    r.v = v; r.op = op; r.fn = fn; r.rs = rs; r.rt = rt; r.rd = rd; r.bt = bt;
    r.comb = comb; r.exv = exv; r.aop = aop; r.src = src; r.br = br; r.exd = exd;
    r.mr = mr; r.mw = mw; r.mrw = mrw; r.md = md; r.wrw = wrw; r.wm2r = wm2r; r.wd = wd;
    return r;
  endfunction

  function automatic logic [25:0] act_regs();
    return {ex_valid, ex_alu_op, ex_alu_src, ex_branch, ex_dst, mem_read, mem_write,
            mem_reg_write, mem_dst, wb_reg_write, wb_mem_to_reg, wb_dst};
  endfunction

  function automatic logic [3:0] act_comb();
    return {stall_o, flush_ifid_o, jump_o, illegal_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic bt);
    id_valid = v; id_opcode = op; id_funct = fn;
    id_rs = rs; id_rt = rt; id_rd = rd; ex_branch_taken = bt;
  endtask

  initial begin
    reset = 1'b1;
    // A J with a taken-branch request during reset must not raise anything
    drive(1, 6'h02, 6'h00, 5'd1, 5'd2, 5'd3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_comb", 32'(act_comb()), 32'h0);
    chk("reset_regs", 32'(act_regs()), 32'h0);
    chk("reset_cnt", 32'(stall_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    //                v  op     fn     rs rt rd bt comb     exv aop src br exd mr mw mrw md wrw m2r wd
    tbl.push_back(mk(1, 6'h00, 6'h20, 1, 2, 3, 0, 4'b0000, 1, 0, 0, 0, 3,  0, 0, 0, 0,  0, 0, 0)); // ADD r3
    tbl.push_back(mk(1, 6'h00, 6'h22, 3, 1, 4, 0, 4'b0000, 1, 1, 0, 0, 4,  0, 0, 1, 3,  0, 0, 0)); // SUB r4
    tbl.push_back(mk(1, 6'h00, 6'h24, 1, 2, 7, 0, 4'b0000, 1, 2, 0, 0, 7,  0, 0, 1, 4,  1, 0, 3)); // AND r7
    tbl.push_back(mk(1, 6'h00, 6'h25, 1, 2, 8, 0, 4'b0000, 1, 3, 0, 0, 8,  0, 0, 1, 7,  1, 0, 4)); // OR r8
    tbl.push_back(mk(1, 6'h00, 6'h2A, 1, 2, 9, 0, 4'b0000, 1, 4, 0, 0, 9,  0, 0, 1, 8,  1, 0, 7)); // SLT r9
    tbl.push_back(mk(1, 6'h23, 6'h00, 1, 5, 0, 0, 4'b0000, 1, 0, 1, 0, 5,  0, 0, 1, 9,  1, 0, 8)); // LW r5
    tbl.push_back(mk(1, 6'h00, 6'h20, 5, 1, 6, 0, 4'b1000, 0, 0, 0, 0, 0,  1, 0, 1, 5,  1, 0, 9)); // ADD r6 stalls
    tbl.push_back(mk(1, 6'h00, 6'h20, 5, 1, 6, 0, 4'b0000, 1, 0, 0, 0, 6,  0, 0, 0, 0,  1, 1, 5)); // re-presented
    tbl.push_back(mk(1, 6'h04, 6'h00, 6, 2, 0, 1, 4'b0000, 1, 1, 0, 1, 0,  0, 0, 1, 6,  0, 0, 0)); // BEQ
    tbl.push_back(mk(1, 6'h23, 6'h00, 2,10, 0, 1, 4'b0100, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 6)); // LW flushed
    tbl.push_back(mk(1, 6'h2B, 6'h00, 1, 2, 0, 0, 4'b0000, 1, 0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0)); // SW
    tbl.push_back(mk(1, 6'h02, 6'h00, 0, 0, 0, 0, 4'b0110, 0, 0, 0, 0, 0,  0, 1, 0, 0,  0, 0, 0)); // J
    tbl.push_back(mk(1, 6'h08, 6'h00, 1, 0, 0, 0, 4'b0000, 1, 0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0)); // ADDI r0
    tbl.push_back(mk(1, 6'h3F, 6'h00, 1, 2, 3, 0, 4'b0001, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0)); // op 111111
    tbl.push_back(mk(1, 6'h00, 6'h21, 1, 2, 3, 0, 4'b0001, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0)); // bad funct
    tbl.push_back(mk(0, 6'h00, 6'h20, 1, 2, 3, 0, 4'b0000, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0)); // invalid
    tbl.push_back(mk(1, 6'h23, 6'h00, 1, 5, 0, 0, 4'b0000, 1, 0, 1, 0, 5,  0, 0, 0, 0,  0, 0, 0)); // LW r5
    tbl.push_back(mk(1, 6'h2B, 6'h00, 5, 7, 0, 0, 4'b1000, 0, 0, 0, 0, 0,  1, 0, 1, 5,  0, 0, 0)); // SW base r5 stalls
    tbl.push_back(mk(1, 6'h2B, 6'h00, 5, 7, 0, 0, 4'b0000, 1, 0, 1, 0, 0,  0, 0, 0, 0,  1, 1, 5)); // SW re-presented
    tbl.push_back(mk(1, 6'h04, 6'h00, 1, 1, 0, 0, 4'b0000, 1, 1, 0, 1, 0,  0, 1, 0, 0,  0, 0, 0)); // BEQ
    tbl.push_back(mk(1, 6'h02, 6'h00, 0, 0, 0, 1, 4'b0100, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0)); // J masked by flush
    tbl.push_back(mk(1, 6'h23, 6'h00, 0, 5, 0, 0, 4'b0000, 1, 0, 1, 0, 5,  0, 0, 0, 0,  0, 0, 0)); // LW r5
    tbl.push_back(mk(1, 6'h00, 6'h20, 0, 5, 6, 0, 4'b1000, 0, 0, 0, 0, 0,  1, 0, 1, 5,  0, 0, 0)); // rt hazard
    tbl.push_back(mk(1, 6'h23, 6'h00, 1, 0, 0, 0, 4'b0000, 1, 0, 1, 0, 0,  0, 0, 0, 0,  1, 1, 5)); // LW r0
    tbl.push_back(mk(1, 6'h00, 6'h20, 0, 0, 6, 0, 4'b0000, 1, 0, 0, 0, 6,  1, 0, 0, 0,  0, 0, 0)); // r0 dst no stall
    tbl.push_back(mk(0, 6'h00, 6'h00, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0,  0, 0, 1, 6,  0, 1, 0)); // drain

    foreach (tbl[i]) begin
      vec_t t;
      logic [25:0] exp_regs;
      t = tbl[i];
      drive(t.v, t.op, t.fn, t.rs, t.rt, t.rd, t.bt);
      #1;
      chk($sformatf("comb[%0d]", i), 32'(act_comb()), 32'(t.comb));
      @(posedge clk);
      #1;
      exp_regs = {t.exv, t.aop, t.src, t.br, t.exd, t.mr, t.mw, t.mrw, t.md, t.wrw, t.wm2r, t.wd};
      chk($sformatf("regs[%0d]", i), 32'(act_regs()), 32'(exp_regs));
      @(negedge clk);
    end

    chk("table_stall_cnt", 32'(stall_count), 32'd3);
    chk("nostall_cnt", 32'(n_stall_count), 32'd0);

    // Reset asserted while a load-use stall is active
    drive(1, 6'h23, 6'h00, 1, 5, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 6'h00, 6'h20, 5, 1, 6, 0);
    #1;
    chk("pre_reset_stall", 32'(stall_o), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_mid_comb", 32'(act_comb()), 32'h0);
    @(posedge clk);
    #1;
    chk("reset_mid_regs", 32'(act_regs()), 32'h0);
    chk("reset_mid_cnt", 32'(stall_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 2^3+3 load-use stalls on a 3-bit counter
    for (int k = 0; k < 11; k++) begin
      drive(1, 6'h23, 6'h00, 1, 5, 0, 0);
      @(posedge clk);
      @(negedge clk);
      drive(1, 6'h00, 6'h20, 5, 1, 6, 0);
      @(posedge clk);
      #1;
      if (k == 6) chk("cnt_at_7", 32'(stall_count), 32'd7);
      @(negedge clk);
    end
    chk("cnt_saturated", 32'(stall_count), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
